ms_uart_frame_rx: RTL and testbench
===================================

Name: ms_uart_frame_rx

Overview:
- Bit-synchronous UART frame decoder, clocked by the TX bit clock internalclk (one cycle per bit).
- Decodes the MS_UART_TX serial frame: start(0), 8 data bits LSB-first, even parity, stop(1).
- Used for on-chip loopback/self-test of the TX path, and as the receive side in the same bit-clock domain.
- Decoded bytes plus error flags are buffered in a small FIFO and drained through a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- SYNC_STAGES, 2, flops on din before decode (0..3); each stage adds one cycle of latency.

Ports:
- internalclk  in  1  bit-rate clock.
- RESETN  in  1  reset, asynchronous, active-high; clock internalclk.
- din  in  1  serial line; idle high.
- out_ready  in  1  consumer accepts the head entry.
- out_valid  out  1  FIFO non-empty.
- dout  out  8  head-entry data byte.
- parity_err  out  1  head-entry parity mismatch.
- frame_err  out  1  head-entry stop bit was 0.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- busy  out  1  decoder not in IDLE.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, bit index=0, shift register=0, sync flops=1, FIFO empty. Outputs: out_valid=0, dout=0, parity_err=0, frame_err=0, overflow=0, busy=0, fifo_count=0.
- The sampled bit s is din after SYNC_STAGES flops.
- IDLE:
  - s==0 → DATA with idx=0, busy=1.
  - s==1 → stay in IDLE.
- DATA: shift[idx]<=s; idx==7 → PARITY, else idx+1.
- PARITY: store p=s → STOP.
- STOP:
  - Form entry {frame_err=(s==0), parity_err=(p != ^shift), data=shift} and push to the FIFO.
  - s==1 → IDLE; s==0 → BREAK.
- BREAK: wait for s==1, then → IDLE. No new start is detected while the line is held low.
- Latency (SYNC_STAGES=0): start bit sampled at edge 0, data edges 1..8, parity edge 9, stop/push edge 10, out_valid=1 after edge 10. Add SYNC_STAGES edges for other settings.
- Back-to-back frames: a start bit directly after the stop bit (at edge 11) is accepted. Throughput is one byte per 11 cycles.
- FIFO behaviour:
  - First-word fall-through: dout, parity_err and frame_err reflect the head entry whenever out_valid=1. When empty, these outputs hold their last values.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle: both happen, and fifo_count is unchanged. This holds even when the FIFO is full, so the push succeeds.
  - Push while full with no pop: the entry is discarded and overflow is set to 1. overflow stays set until reset.
  - Pointers wrap modulo DEPTH.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: MS_UART_FRAME_RX_PARITY_EN.
- Defined: the frame includes a parity bit, PARITY state as above, 11-bit frame. This matches MS_UART_TX.
- Undefined:
  - PARITY state removed; DATA idx==7 goes directly to STOP.
  - 10-bit frame; push at edge 9 (SYNC_STAGES=0).
  - parity_err tied to 0.

Decomposition:
- Package ms_uart_pkg:
  - UART_DATA_W=8.
  - State encoding: IDLE, DATA, PARITY, STOP, BREAK.
  - FIFO entry struct {frame_err, parity_err, data[7:0]} and its width constant.
- Sub-module ms_uart_sync_fifo: generic DEPTH×WIDTH first-word fall-through FIFO.
  - Ports: push, pop, full, empty, count.
  - Async active-high reset.
  - Simultaneous push/pop when full is allowed.

Test Plan (defaults SYNC_STAGES=2, macro defined, out_ready=1 unless noted):
- Frame 0xA5 with parity 0 and stop 1 → out_valid rises 13 edges after the start bit is applied; dout=0xA5, parity_err=0, frame_err=0.
- Frame 0x07 with parity 0 (wrong; correct is 1) → dout=0x07, parity_err=1, frame_err=0.
- Frame 0x3C with stop=0, line held low 5 more cycles, then a frame of 0x55 → first entry 0x3C with frame_err=1; no spurious frame during the low period; second entry 0x55 clean.
- out_ready=0, six back-to-back frames 0x01..0x06 → fifo_count=4, overflow=1; draining yields 0x01,0x02,0x03,0x04.
- FIFO full, out_ready=1 pulsed on the same edge as a push of 0x99 → count stays 4, overflow stays 0; 0x99 is drained last.
- RESETN pulsed during data bit 4 → outputs at reset values immediately; the next clean frame 0xC3 decodes correctly.

Source files
------------

// File: rtl/ms_uart_pkg.sv
// ms_uart_pkg
// Shared definitions for the MS_UART receive path.
//   - UART_DATA_W  : width of one UART data byte.
//   - ST_*         : decoder state encoding (localparam constants).
//   - rx_entry_t   : one decoded frame as stored in the receive FIFO.
//   - RX_ENTRY_W   : packed width of rx_entry_t.
//   - even_parity(): even-parity bit that makes the total count of ones even.

package ms_uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    // Decoder state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;

    typedef struct packed {
        logic                   frame_err;
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    localparam int unsigned RX_ENTRY_W = $bits(rx_entry_t);

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ms_uart_sync_fifo.sv
// ms_uart_sync_fifo
// Generic DEPTH x WIDTH first-word fall-through FIFO, single clock.
// rdata always shows the head entry; it is only meaningful while empty=0.
// A push is accepted when not full, or when full and a pop happens on the same edge.
// Ports:
//   internalclk  in   clock
//   RESETN       in   asynchronous, active-high reset
//   push         in   write wdata this cycle
//   wdata        in   entry to write
//   pop          in   remove head entry (ignored when empty)
//   rdata        out  head entry
//   full         out  DEPTH entries held
//   empty        out  no entries held
//   count        out  occupancy, 0..DEPTH

module ms_uart_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     internalclk,
    input  logic                     RESETN,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A pop frees the slot on the same edge, so a push into a full FIFO succeeds then.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge internalclk or posedge RESETN) begin
        if (RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge internalclk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ms_uart_frame_rx.sv
// ms_uart_frame_rx
// Bit-synchronous UART frame decoder running on the TX bit clock (one cycle per bit).
// Frame: start(0), 8 data bits LSB-first, [even parity], stop(1).
// Decoded bytes plus error flags are queued in a FWFT FIFO and drained by valid/ready.
//
// Build option:
//   MS_UART_FRAME_RX_PARITY_EN  defined   -> 11-bit frame with even parity bit.
//                               undefined -> 10-bit frame, no parity bit, parity_err=0.
//
// Ports:
//   internalclk  in   bit-rate clock
//   RESETN       in   asynchronous, active-high reset
//   din          in   serial line, idle high
//   out_ready    in   consumer accepts the head entry
//   out_valid    out  FIFO non-empty
//   dout         out  head-entry data byte (holds last popped value when empty)
//   parity_err   out  head-entry parity mismatch
//   frame_err    out  head-entry stop bit was 0
//   overflow     out  sticky: a frame was dropped because the FIFO was full
//   busy         out  decoder not idle
//   fifo_count   out  FIFO occupancy

module ms_uart_frame_rx
    import ms_uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   internalclk,
    input  logic                   RESETN,
    input  logic                   din,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overflow,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    // ------------------------------------------------------------------
    // Input synchroniser; sampled bit s is din after SYNC_STAGES flops.
    // ------------------------------------------------------------------
    logic s;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign s = din;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge internalclk or posedge RESETN) begin
            if (RESETN) begin
                sync_q <= '1;
            end else begin
                sync_q[0] <= din;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    logic [2:0]             state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
`ifdef MS_UART_FRAME_RX_PARITY_EN
    logic                   par_q, par_d;
`endif
    logic                   push;
    rx_entry_t              push_entry;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef MS_UART_FRAME_RX_PARITY_EN
        par_d   = par_q;
`endif
        push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                shift_d[idx_q] = s;
                // Index wraps back to 0 after bit 7, ready for the next frame.
                idx_d          = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
`ifdef MS_UART_FRAME_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef MS_UART_FRAME_RX_PARITY_EN
            ST_PARITY: begin
                par_d   = s;
                state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                push    = 1'b1;
                // A low stop bit means the line may be in break; wait for it to idle.
                state_d = s ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        push_entry.frame_err  = ~s;
`ifdef MS_UART_FRAME_RX_PARITY_EN
        push_entry.parity_err = (par_q != even_parity(shift_q));
`else
        push_entry.parity_err = 1'b0;
`endif
        push_entry.data       = shift_q;
    end

    always_ff @(posedge internalclk or posedge RESETN) begin
        if (RESETN) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef MS_UART_FRAME_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef MS_UART_FRAME_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Receive FIFO and output handshake
    // ------------------------------------------------------------------
    logic                  fifo_full, fifo_empty, pop;
    logic [RX_ENTRY_W-1:0] fifo_rdata;
    rx_entry_t             fifo_head, held_q, head;
    logic                  overflow_q;

    ms_uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_fifo (
        .internalclk (internalclk),
        .RESETN      (RESETN),
        .push        (push),
        .wdata       (push_entry),
        .pop         (pop),
        .rdata       (fifo_rdata),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    assign fifo_head = fifo_rdata;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    // When the FIFO empties the outputs keep showing the last entry handed out.
    assign head = fifo_empty ? held_q : fifo_head;

    always_ff @(posedge internalclk or posedge RESETN) begin
        if (RESETN) begin
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                held_q <= fifo_head;
            end
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign dout       = head.data;
    assign parity_err = head.parity_err;
    assign frame_err  = head.frame_err;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ms_uart_frame_rx.sv
module tb_ms_uart_frame_rx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
`ifdef MS_UART_FRAME_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int LATENCY = 13;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int LATENCY = 12;
`endif

    logic       internalclk = 1'b0;
    logic       RESETN;
    logic       din;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       busy;
    logic [2:0] fifo_count;

    ms_uart_frame_rx #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .internalclk (internalclk),
        .RESETN      (RESETN),
        .din         (din),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .dout        (dout),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 internalclk = ~internalclk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake pops one expected entry.
    always @(negedge internalclk) begin
        if (RESETN === 1'b0 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: got dout %0h, expected no entry (t=%0t)",
                         dout, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout", dout, e.d);
                check("parity_err", parity_err, e.pe);
                check("frame_err", frame_err, e.fe);
            end
        end
    end

    task automatic expect_entry(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = PAR_EN ? pe : 1'b0;
        e.fe = fe;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        din = b;
        @(posedge internalclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(p);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) begin
            @(posedge internalclk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 200) begin
            @(posedge internalclk);
            #1;
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending entries, expected 0", sb.size());
        end
        idle(3);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    // Correct even parity for 0x01..0x06
    logic [6:1] par_tab = 6'b001011;

    initial begin
        RESETN    = 1'b1;
        din       = 1'b1;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        #10;
        RESETN = 1'b0;
        @(posedge internalclk);
        #1;
        idle(2);

        // Clean frame and start-to-valid latency
        expect_entry(8'hA5, 1'b0, 1'b0);
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                int n;
                n = 0;
                while (!out_valid && n < 40) begin
                    @(posedge internalclk);
                    #1;
                    n++;
                end
                check("latency_edges", n, LATENCY);
            end
        join
        wait_drain();

        // Wrong parity
        expect_entry(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_drain();

        // Framing error, line held low, then a clean frame
        expect_entry(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (5) send_bit(1'b0);
        check("busy_in_break", busy, 1);
        idle(2);
        expect_entry(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        wait_drain();

        // Overflow: six frames into a 4-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) expect_entry(8'(i), 1'b0, 1'b0);
            send_frame(8'(i), par_tab[i], 1'b1);
        end
        idle(3);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", dout, 8'h01);
        out_ready = 1'b1;
        wait_drain();
        check("ovf_sticky", overflow, 1);
        check("held_dout", dout, 8'h04);
        check("drained_count", fifo_count, 0);

        // Reset asserted during data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        din = 1'b1;
        #1;
        RESETN = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fifo_count", fifo_count, 0);
        #4;
        RESETN = 1'b0;
        sb.delete();
        @(posedge internalclk);
        #1;
        idle(3);
        expect_entry(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1);
        wait_drain();

        // Full FIFO: pop on the same edge as the push of 0x99
        out_ready = 1'b0;
        expect_entry(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1);
        expect_entry(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1);
        expect_entry(8'h13, 1'b0, 1'b0);
        send_frame(8'h13, 1'b1, 1'b1);
        expect_entry(8'h14, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b1);
        expect_entry(8'h99, 1'b0, 1'b0);
        send_frame(8'h99, 1'b0, 1'b1);
        @(posedge internalclk);
        #1;
        check("full_before_push", fifo_count, 4);
        out_ready = 1'b1;
        @(posedge internalclk);
        #1;
        out_ready = 1'b0;
        check("simul_count", fifo_count, 4);
        check("simul_overflow", overflow, 0);
        out_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
